// File: rtl/main_mem_read_arbiter.sv
// Round-robin arbiter sharing one main-memory read port among NUM_CORES cores.
// One read in flight at a time; the returned word goes to the granted core with a one-cycle pulse.
module main_mem_read_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          iEnable,
  input  logic [NUM_CORES-1:0]          iCoreReadRequest,
  input  logic [NUM_CORES*ADDR_W-1:0]   iCoreReadAddress,
  output logic [NUM_CORES-1:0]          oCoreDataAvailable,
  output logic [DATA_W-1:0]             oCoreReadData,
  output logic                          oMEM_ReadRequest,
  output logic [ADDR_W-1:0]             oMemReadAddress,
  input  logic                          iMemDataAvailable,
  input  logic [DATA_W-1:0]             iMemReadData,
  output logic                          oBusy,
  output logic [$clog2(NUM_CORES)-1:0]  oGrantIndex
);

  localparam int IDX_W = $clog2(NUM_CORES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t                 r_state;
  logic [IDX_W-1:0]       r_rr_ptr;
  logic [IDX_W-1:0]       r_grant;
  logic [ADDR_W-1:0]      r_addr;
  logic                   r_req;
  logic [DATA_W-1:0]      r_data;
  logic [NUM_CORES-1:0]   r_dav;
  logic                   r_busy;

  state_t                 w_state_nxt;
  logic [IDX_W-1:0]       w_rr_ptr_nxt;
  logic [IDX_W-1:0]       w_grant_nxt;
  logic [ADDR_W-1:0]      w_addr_nxt;
  logic                   w_req_nxt;
  logic [DATA_W-1:0]      w_data_nxt;
  logic [NUM_CORES-1:0]   w_dav_nxt;
  logic                   w_busy_nxt;

  logic [2*NUM_CORES-1:0] w_rot_wide;
  logic [NUM_CORES-1:0]   w_rot;
  logic [IDX_W-1:0]       w_off;
  logic                   w_found;
  logic [IDX_W:0]         w_sum;
  logic [IDX_W-1:0]       w_sel;
  logic [IDX_W-1:0]       w_ptr_after;
  logic [ADDR_W-1:0]      w_core_addr [NUM_CORES];

  genvar g;
  generate
    for (g = 0; g < NUM_CORES; g++) begin : g_addr
      assign w_core_addr[g] = iCoreReadAddress[g*ADDR_W +: ADDR_W];
    end
  endgenerate

  // Rotate requests so bit 0 is the rr_ptr core; the lowest set bit is the winner.
  always_comb begin
    w_rot_wide = {iCoreReadRequest, iCoreReadRequest} >> r_rr_ptr;
    w_rot      = w_rot_wide[NUM_CORES-1:0];
    w_off      = {IDX_W{1'b0}};
    w_found    = 1'b0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off   = IDX_W'(k);
        w_found = 1'b1;
      end else begin
        w_off   = w_off;
        w_found = w_found;
      end
    end
    w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
    if (w_sum >= (IDX_W+1)'(NUM_CORES)) begin
      w_sum = w_sum - (IDX_W+1)'(NUM_CORES);
    end else begin
      w_sum = w_sum;
    end
    w_sel = w_sum[IDX_W-1:0];
    if (r_grant == IDX_W'(NUM_CORES - 1)) begin
      w_ptr_after = {IDX_W{1'b0}};
    end else begin
      w_ptr_after = r_grant + IDX_W'(1);
    end
  end

  // Next-state and registered-output values.
  always_comb begin
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    w_grant_nxt  = r_grant;
    w_addr_nxt   = r_addr;
    w_req_nxt    = r_req;
    w_data_nxt   = r_data;
    w_dav_nxt    = {NUM_CORES{1'b0}};
    case (r_state)
      ST_IDLE: begin
        if (iEnable && w_found) begin
          w_grant_nxt = w_sel;
          w_addr_nxt  = w_core_addr[w_sel];
          w_req_nxt   = 1'b1;
          w_state_nxt = ST_REQ;
        end else begin
          w_req_nxt   = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (iMemDataAvailable) begin
          w_data_nxt   = iMemReadData;
          w_dav_nxt    = NUM_CORES'(1) << r_grant;
          w_req_nxt    = 1'b0;
          w_rr_ptr_nxt = w_ptr_after;
          w_state_nxt  = ST_RELEASE;
        end else begin
          w_req_nxt    = 1'b1;
          w_state_nxt  = ST_REQ;
        end
      end
      // A valid still high from the finished read must clear before the next grant.
      ST_RELEASE: begin
        if (!iMemDataAvailable) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RELEASE;
        end
      end
      default: begin
        w_req_nxt   = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= {IDX_W{1'b0}};
      r_grant  <= {IDX_W{1'b0}};
      r_addr   <= {ADDR_W{1'b0}};
      r_req    <= 1'b0;
      r_data   <= {DATA_W{1'b0}};
      r_dav    <= {NUM_CORES{1'b0}};
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_grant  <= w_grant_nxt;
      r_addr   <= w_addr_nxt;
      r_req    <= w_req_nxt;
      r_data   <= w_data_nxt;
      r_dav    <= w_dav_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign oCoreDataAvailable = r_dav;
  assign oCoreReadData      = r_data;
  assign oMEM_ReadRequest   = r_req;
  assign oMemReadAddress    = r_addr;
  assign oBusy              = r_busy;
  assign oGrantIndex        = r_grant;

endmodule

// File: tb/tb_main_mem_read_arbiter.sv
// Randomized bench for main_mem_read_arbiter against a transaction-level model
// plus a latency-configurable echoing memory.
module tb_main_mem_read_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 2;

  logic            Clock = 1'b0;
  logic            Reset = 1'b0;
  logic            iEnable = 1'b0;
  logic [N-1:0]    iCoreReadRequest = '0;
  logic [N*AW-1:0] iCoreReadAddress = '0;
  logic [N-1:0]    oCoreDataAvailable;
  logic [DW-1:0]   oCoreReadData;
  logic            oMEM_ReadRequest;
  logic [AW-1:0]   oMemReadAddress;
  logic            iMemDataAvailable = 1'b0;
  logic [DW-1:0]   iMemReadData = '0;
  logic            oBusy;
  logic [IW-1:0]   oGrantIndex;

  main_mem_read_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .Clock(Clock), .Reset(Reset), .iEnable(iEnable),
    .iCoreReadRequest(iCoreReadRequest), .iCoreReadAddress(iCoreReadAddress),
    .oCoreDataAvailable(oCoreDataAvailable), .oCoreReadData(oCoreReadData),
    .oMEM_ReadRequest(oMEM_ReadRequest), .oMemReadAddress(oMemReadAddress),
    .iMemDataAvailable(iMemDataAvailable), .iMemReadData(iMemReadData),
    .oBusy(oBusy), .oGrantIndex(oGrantIndex)
  );

  always #5 Clock = ~Clock;

  int tests = 0;
  int fails = 0;

  // transaction-level model: one read outstanding, then a drain until memory valid clears
  bit            m_reading, m_draining;
  int            m_owner, m_ptr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            waits [N];
  int            grant_log [$];
  int            pulse_cnt;

  int mem_lat = 1, mem_cnt = 0, mem_hold = 0, mem_maxhold = 0;
  bit persist = 1'b0, rand_req = 1'b0;

  function automatic logic [DW-1:0] memfn(input logic [AW-1:0] a);
    if (a == 32'h5) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_reading = 0; m_draining = 0; m_owner = 0; m_ptr = 0; m_addr = '0; m_data = '0;
    for (int i = 0; i < N; i++) waits[i] = 0;
    mem_cnt = 0; mem_hold = 0;
    iMemDataAvailable = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #1;
    check("rst_pulse", 64'(oCoreDataAvailable), 64'h0);
    check("rst_data",  64'(oCoreReadData),      64'h0);
    check("rst_mreq",  64'(oMEM_ReadRequest),   64'h0);
    check("rst_addr",  64'(oMemReadAddress),    64'h0);
    check("rst_busy",  64'(oBusy),              64'h0);
    check("rst_grant", 64'(oGrantIndex),        64'h0);
    model_reset();
    @(posedge Clock); #1;
    Reset = 1'b0;
  endtask

  task automatic step();
    logic [N-1:0]    p_req;
    logic [N*AW-1:0] p_addr;
    logic            p_en, p_dav, p_mreq;
    logic [DW-1:0]   p_md;
    logic [AW-1:0]   p_maddr;
    logic [N-1:0]    exp_pulse;
    int              gsel;
    p_req = iCoreReadRequest; p_addr = iCoreReadAddress; p_en = iEnable;
    p_dav = iMemDataAvailable; p_md = iMemReadData;
    p_mreq = oMEM_ReadRequest; p_maddr = oMemReadAddress;
    @(posedge Clock); #1;
    exp_pulse = '0;
    if (m_reading) begin
      if (p_dav) begin
        m_data = p_md; exp_pulse[m_owner] = 1'b1;
        m_reading = 0; m_draining = 1; m_ptr = (m_owner + 1) % N;
      end
    end else if (m_draining) begin
      if (!p_dav) m_draining = 0;
    end else if (p_en && p_req != '0) begin
      gsel = -1;
      for (int k = 0; k < N; k++)
        if (gsel < 0 && p_req[(m_ptr + k) % N]) gsel = (m_ptr + k) % N;
      m_reading = 1; m_owner = gsel; m_addr = p_addr[gsel*AW +: AW];
      grant_log.push_back(gsel);
      check("fair_wait", 64'(waits[gsel] < N), 64'h1);
      for (int j = 0; j < N; j++)
        if (j == gsel) waits[j] = 0; else if (p_req[j]) waits[j]++;
    end
    for (int j = 0; j < N; j++) if (!p_req[j]) waits[j] = 0;

    if (oCoreDataAvailable != '0) pulse_cnt++;
    check("mem_req", 64'(oMEM_ReadRequest), 64'(m_reading));
    if (m_reading) check("mem_addr", 64'(oMemReadAddress), 64'(m_addr));
    check("grant", 64'(oGrantIndex), 64'(m_owner));
    check("busy", 64'(oBusy), 64'(m_reading | m_draining));
    check("pulse", 64'(oCoreDataAvailable), 64'(exp_pulse));
    if (exp_pulse != '0) check("rdata", 64'(oCoreReadData), 64'(m_data));

    // memory registers the request it saw before the edge, echoing valid with one cycle of lag
    if (p_mreq) begin
      mem_cnt++;
      if (mem_cnt >= mem_lat) begin
        iMemDataAvailable = 1'b1; iMemReadData = memfn(p_maddr);
        mem_hold = $urandom_range(mem_maxhold, 0);
      end else begin
        iMemDataAvailable = 1'b0; iMemReadData = $urandom;
      end
    end else begin
      mem_cnt = 0;
      if (iMemDataAvailable && mem_hold > 0) mem_hold--;
      else begin iMemDataAvailable = 1'b0; iMemReadData = $urandom; end
    end

    for (int i = 0; i < N; i++) begin
      if (exp_pulse[i] && !persist) iCoreReadRequest[i] = 1'b0;
      else if (!iCoreReadRequest[i] && rand_req && $urandom_range(3, 0) == 0) begin
        iCoreReadRequest[i] = 1'b1;
        iCoreReadAddress[i*AW +: AW] = AW'($urandom_range(1023, 0));
      end
    end
  endtask

  int exp_all [5] = '{0, 1, 2, 3, 0};
  int exp_alt [4] = '{0, 3, 0, 3};

  initial begin
    #2;
    do_reset();

    // single read: core 2, address 5, 1-cycle memory
    iEnable = 1'b1;
    iCoreReadAddress[2*AW +: AW] = 32'h5;
    iCoreReadRequest = 4'b0100;
    step();
    check("t2_addr", 64'(oMemReadAddress), 64'h5);
    check("t2_mreq", 64'(oMEM_ReadRequest), 64'h1);
    check("t2_gidx", 64'(oGrantIndex), 64'h2);
    step();
    check("t2_nopulse", 64'(oCoreDataAvailable), 64'h0);
    step();
    check("t2_pulse", 64'(oCoreDataAvailable), 64'h4);
    check("t2_data", 64'(oCoreReadData), 64'hDEADBEEF);
    step();
    check("t2_pulse_end", 64'(oCoreDataAvailable), 64'h0);
    step();
    check("t2_idle", 64'(oBusy), 64'h0);
    repeat (2) step();

    // all four request continuously
    do_reset();
    persist = 1'b1;
    for (int i = 0; i < N; i++) iCoreReadAddress[i*AW +: AW] = AW'(32'h10 + i);
    iCoreReadRequest = 4'b1111;
    grant_log.delete();
    for (int c = 0; c < 200 && grant_log.size() < 5; c++) step();
    check("t3_count", 64'(grant_log.size() >= 5), 64'h1);
    for (int k = 0; k < 5 && k < grant_log.size(); k++) check("t3_order", 64'(grant_log[k]), 64'(exp_all[k]));

    // cores 0 and 3 alternate
    do_reset();
    iCoreReadRequest = 4'b1001;
    grant_log.delete();
    for (int c = 0; c < 200 && grant_log.size() < 4; c++) step();
    check("t4_count", 64'(grant_log.size() >= 4), 64'h1);
    for (int k = 0; k < 4 && k < grant_log.size(); k++) check("t4_order", 64'(grant_log[k]), 64'(exp_alt[k]));

    // 6-cycle memory
    do_reset();
    persist = 1'b0; mem_lat = 6;
    iCoreReadAddress[1*AW +: AW] = 32'h77;
    iCoreReadRequest = 4'b0010;
    pulse_cnt = 0;
    repeat (16) step();
    check("t5_pulses", 64'(pulse_cnt), 64'h1);
    mem_lat = 1;

    // enable gating and reset during REQ
    do_reset();
    persist = 1'b1; iEnable = 1'b0;
    iCoreReadRequest = 4'b0010;
    repeat (5) step();
    check("t6_nogrant_busy", 64'(oBusy), 64'h0);
    check("t6_nogrant_mreq", 64'(oMEM_ReadRequest), 64'h0);
    iEnable = 1'b1;
    step();
    iEnable = 1'b0;
    pulse_cnt = 0;
    repeat (12) step();
    check("t6_complete", 64'(pulse_cnt), 64'h1);
    check("t6_no_regrant", 64'(oBusy), 64'h0);
    mem_lat = 4; iEnable = 1'b1;
    step();
    step();
    check("t6_in_req", 64'(oMEM_ReadRequest), 64'h1);
    do_reset();
    iEnable = 1'b0; pulse_cnt = 0;
    repeat (10) step();
    check("t6_abort_nopulse", 64'(pulse_cnt), 64'h0);

    // randomized traffic
    persist = 1'b0; rand_req = 1'b1; iEnable = 1'b1;
    iCoreReadRequest = '0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 50 == 0) begin
        mem_lat = $urandom_range(6, 1);
        mem_maxhold = $urandom_range(2, 0);
      end
      iEnable = ($urandom_range(7, 0) != 0);
      if ($urandom_range(399, 0) == 0) do_reset();
      else step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
